multdiv_controller: RTL and testbench
=====================================

MULTDIV_CONTROLLER -- requirements
Module: multdiv_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40: max BUSY cycles before the operation is abandoned.
REQ-002 SHALL have parameter RSTATUS_REG, default 30: register index written on exception.
REQ-003 SHALL have port clock  input  1  single processor clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port issue_valid  input  1  valid instruction present in execute stage.
REQ-006 SHALL have port opcode  input  5  execute-stage opcode.
REQ-007 SHALL have port aluop  input  5  execute-stage ALU op field.
REQ-008 SHALL have port rd  input  5  execute-stage destination register.
REQ-009 SHALL have port unit_ready  input  1  multdiv unit result valid.
REQ-010 SHALL have port unit_result  input  32  multdiv unit result.
REQ-011 SHALL have port unit_exception  input  1  multdiv unit overflow / divide-by-zero.
REQ-012 SHALL have port ctrl_mult  output  1  one-cycle start pulse for multiply.
REQ-013 SHALL have port ctrl_div  output  1  one-cycle start pulse for divide.
REQ-014 SHALL have port stall  output  1  freeze PC and pipeline registers.
REQ-015 SHALL have port wb_en  output  1  regfile write enable for multdiv result.
REQ-016 SHALL have port wb_reg  output  5  regfile write index.
REQ-017 SHALL have port wb_data  output  32  regfile write data.
REQ-018 SHALL have port timeout_err  output  1  sticky flag, operation timed out.

Function
REQ-019 SHALL decode mul as opcode 00000 & aluop 00110 and div as opcode 00000 & aluop 00111; all other encodings are ignored.
REQ-020 SHALL implement states IDLE, BUSY, DONE; reset state IDLE.
REQ-021 IDLE: on issue_valid & (mul|div) SHALL assert ctrl_mult or ctrl_div and stall combinationally in that cycle, latch rd and op type, clear the cycle counter, and go to BUSY.
REQ-022 IDLE: stall, wb_en, ctrl_mult, ctrl_div SHALL be 0 when no mul/div is issued; unit_ready SHALL be ignored.
REQ-023 BUSY: stall SHALL be 1; ctrl_mult/ctrl_div SHALL be 0; counter increments each cycle starting at 1 in the first BUSY cycle.
REQ-024 BUSY: on unit_ready SHALL capture unit_result and unit_exception and go to DONE; a ready coincident with the start cycle (IDLE) SHALL NOT count.
REQ-025 BUSY: when counter equals TIMEOUT without unit_ready SHALL go to DONE with captured exception=1, result=0, and set timeout_err; unit_ready in that same cycle takes priority over the timeout.
REQ-026 DONE: stall SHALL be 0 for exactly one cycle, then return to IDLE; issue_valid in DONE SHALL be ignored.
REQ-027 DONE, no exception: wb_en=1 iff latched rd != 0; wb_reg=latched rd; wb_data=captured result.
REQ-028 DONE, exception: wb_en=1; wb_reg=RSTATUS_REG; wb_data=4 for mul, 5 for div, zero-extended to 32 bits.
REQ-029 Outside DONE, wb_en SHALL be 0 and wb_reg, wb_data SHALL be 0.
REQ-030 Latency SHALL be N+2 stalled-cycle-inclusive cycles, start through DONE, when unit_ready arrives in BUSY cycle N.

Reset
REQ-031 reset SHALL force IDLE, clear counter, latched rd/op/result/exception and timeout_err, and drive all outputs to 0 on the next edge, including mid-BUSY or DONE.
REQ-032 reset SHALL take priority over every other input in the same cycle.

Verification
REQ-033 mul, rd=5, unit_ready in BUSY cycle 3, result 0x0000_0015 -> ctrl_mult one pulse, stall 4 cycles, DONE wb_en=1 wb_reg=5 wb_data=0x15.
REQ-034 div, rd=7, unit_ready with unit_exception=1 -> wb_reg=30, wb_data=5; mul exception -> wb_data=4.
REQ-035 mul, rd=0, no exception -> wb_en stays 0 in DONE; stall still released after one DONE cycle.
REQ-036 div with unit_ready never asserted -> DONE after 40 BUSY cycles, wb_reg=30 wb_data=5, timeout_err=1 until reset.
REQ-037 reset asserted in BUSY cycle 2 -> next cycle IDLE, stall=0, no writeback when a later unit_ready arrives.
REQ-038 back-to-back mul issues, second presented in DONE then in IDLE -> only the IDLE presentation starts a new operation.

Source files
------------

// File: rtl/multdiv_controller.sv
// multdiv_controller: sequences multiply/divide ops, stalls the pipeline and writes back the result or an exception code.
module multdiv_controller #(
    parameter int TIMEOUT     = 40,
    parameter int RSTATUS_REG = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  opcode,
    input  logic [4:0]  aluop,
    input  logic [4:0]  rd,
    input  logic        unit_ready,
    input  logic [31:0] unit_result,
    input  logic        unit_exception,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        stall,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        timeout_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [4:0] RS = RSTATUS_REG[4:0];
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [4:0] rd_q;
    logic op_div, exc_q;
    logic [31:0] res_q;
    logic is_mul, is_div, start, done;
    assign is_mul = opcode == 5'b00000 && aluop == 5'b00110;
    assign is_div = opcode == 5'b00000 && aluop == 5'b00111;
    // start pulse is combinational so the unit launches in the issue cycle itself
    assign start = !reset && state == IDLE && issue_valid && (is_mul || is_div);
    assign done = state == DONE;
    assign ctrl_mult = start && is_mul;
    assign ctrl_div = start && is_div;
    assign stall = start || state == BUSY;
    assign wb_en = done && (exc_q || rd_q != 5'd0);
    assign wb_reg = !done ? 5'd0 : exc_q ? RS : rd_q;
    assign wb_data = !done ? 32'd0 : exc_q ? (op_div ? 32'd5 : 32'd4) : res_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            rd_q <= '0;
            op_div <= 1'b0;
            exc_q <= 1'b0;
            res_q <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    rd_q <= rd;
                    op_div <= is_div;
                    cnt <= CW'(1);
                    state <= BUSY;
                end
                BUSY: begin
                    cnt <= cnt + CW'(1);
                    if (unit_ready) begin
                        res_q <= unit_result;
                        exc_q <= unit_exception;
                        state <= DONE;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        res_q <= '0;
                        exc_q <= 1'b1;
                        timeout_err <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_controller.sv
// tb_multdiv_controller: directed transactions with per-cycle expectations derived from each transaction's parameters.
module tb_multdiv_controller;
    localparam int TIMEOUT = 40;
    logic clock = 1'b0;
    logic reset, issue_valid, unit_ready, unit_exception;
    logic [4:0] opcode, aluop, rd;
    logic [31:0] unit_result;
    logic ctrl_mult, ctrl_div, stall, wb_en, timeout_err;
    logic [4:0] wb_reg;
    logic [31:0] wb_data;

    multdiv_controller #(.TIMEOUT(TIMEOUT), .RSTATUS_REG(30)) dut (
        .clock(clock), .reset(reset), .issue_valid(issue_valid), .opcode(opcode),
        .aluop(aluop), .rd(rd), .unit_ready(unit_ready), .unit_result(unit_result),
        .unit_exception(unit_exception), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
        .stall(stall), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int passed = 0, total = 0;
    bit chk_en = 0;
    logic e_mult, e_div, e_stall, e_wben, e_terr;
    logic [4:0] e_reg;
    logic [31:0] e_data;
    int stall_cnt, mult_cnt, div_cnt;
    logic [63:0] last_wb;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        else passed++;
    endtask

    always @(negedge clock) if (chk_en) begin
        chk("ctrl_mult", 64'(ctrl_mult), 64'(e_mult));
        chk("ctrl_div", 64'(ctrl_div), 64'(e_div));
        chk("stall", 64'(stall), 64'(e_stall));
        chk("wb_en", 64'(wb_en), 64'(e_wben));
        chk("wb_reg", 64'(wb_reg), 64'(e_reg));
        chk("wb_data", 64'(wb_data), 64'(e_data));
        chk("timeout_err", 64'(timeout_err), 64'(e_terr));
        if (stall) stall_cnt++;
        if (ctrl_mult) mult_cnt++;
        if (ctrl_div) div_cnt++;
        if (wb_en) last_wb = {27'd0, wb_reg, wb_data};
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_outs();
        e_mult = 0; e_div = 0; e_stall = 0; e_wben = 0; e_reg = 0; e_data = 0;
    endtask

    // n = BUSY cycle in which unit_ready arrives, 0 = never (timeout); rst_at = BUSY cycle with reset, 0 = none
    task automatic run_op(input bit dv, input logic [4:0] r, input int n, input logic [31:0] res,
                          input bit ex, input int rst_at, input bit early_rdy, input bit done_issue);
        int last;
        bit xe;
        stall_cnt = 0; mult_cnt = 0; div_cnt = 0; last_wb = 0;
        issue_valid = 1; opcode = 0; aluop = dv ? 5'd7 : 5'd6; rd = r;
        unit_ready = early_rdy; unit_result = early_rdy ? 32'hDEAD : 0; unit_exception = early_rdy;
        idle_outs(); e_mult = !dv; e_div = dv; e_stall = 1;
        tick();
        last = (n > 0) ? n : TIMEOUT;
        for (int k = 1; k <= last; k++) begin
            issue_valid = 0; rd = 5'd9;
            unit_ready = (k == n);
            unit_result = (k == n) ? res : 32'hFFFF_FFFF;
            unit_exception = (k == n) ? ex : 1'b1;
            reset = (k == rst_at);
            idle_outs(); e_stall = 1;
            tick();
            if (k == rst_at) begin
                reset = 0; unit_ready = 0; e_terr = 0; idle_outs();
                tick();
                unit_ready = 1; unit_result = 32'h77; unit_exception = 0;
                tick();
                tick();
                unit_ready = 0;
                tick();
                return;
            end
        end
        xe = (n == 0) || ex;
        unit_ready = 0; unit_exception = 0;
        if (done_issue) begin issue_valid = 1; opcode = 0; aluop = 5'd6; rd = 5'd3; end
        if (n == 0) e_terr = 1;
        idle_outs();
        e_wben = xe || r != 0;
        e_reg = xe ? 5'd30 : r;
        e_data = xe ? (dv ? 32'd5 : 32'd4) : res;
        tick();
        issue_valid = 0;
        idle_outs();
        tick();
    endtask

    logic [4:0] junk_op [4] = '{5'd0, 5'd1, 5'd0, 5'd31};
    logic [4:0] junk_al [4] = '{5'd5, 5'd6, 5'd8, 5'd7};

    initial begin
        reset = 1; issue_valid = 0; opcode = 0; aluop = 0; rd = 0;
        unit_ready = 0; unit_result = 0; unit_exception = 0;
        tick();
        idle_outs(); e_terr = 0; chk_en = 1;
        tick();
        reset = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1; opcode = junk_op[i]; aluop = junk_al[i]; rd = 5'd4;
            unit_ready = 1; unit_result = 32'h1234;
            tick();
        end
        issue_valid = 0; opcode = 0; aluop = 5'd6;
        tick();
        unit_ready = 0;

        run_op(0, 5'd5, 3, 32'h15, 0, 0, 0, 0);
        chk("mul_stall_cycles", 64'(stall_cnt), 64'd4);
        chk("mul_pulses", 64'(mult_cnt), 64'd1);
        chk("mul_wb", last_wb, {27'd0, 5'd5, 32'h15});

        run_op(1, 5'd7, 2, 32'h1234, 1, 0, 0, 0);
        chk("div_exc_wb", last_wb, {27'd0, 5'd30, 32'd5});
        chk("div_pulses", 64'(div_cnt), 64'd1);

        run_op(0, 5'd12, 1, 32'h99, 1, 0, 0, 0);
        chk("mul_exc_wb", last_wb, {27'd0, 5'd30, 32'd4});

        run_op(0, 5'd0, 2, 32'h42, 0, 0, 0, 0);
        chk("rd0_no_wb", last_wb, 64'd0);
        chk("rd0_stall_cycles", 64'(stall_cnt), 64'd3);

        run_op(0, 5'd4, 5, 32'hAA, 0, 0, 1, 0);
        chk("early_ready_stall", 64'(stall_cnt), 64'd6);
        chk("early_ready_wb", last_wb, {27'd0, 5'd4, 32'hAA});

        run_op(1, 5'd8, TIMEOUT, 32'hAB, 0, 0, 0, 0);
        chk("ready_beats_timeout", last_wb, {27'd0, 5'd8, 32'hAB});
        chk("no_timeout_flag", 64'(timeout_err), 64'd0);

        run_op(1, 5'd7, 0, 32'h0, 0, 0, 0, 0);
        chk("timeout_stall", 64'(stall_cnt), 64'd41);
        chk("timeout_wb", last_wb, {27'd0, 5'd30, 32'd5});
        chk("timeout_sticky", 64'(timeout_err), 64'd1);

        run_op(0, 5'd3, 2, 32'h5, 0, 0, 0, 1);
        chk("done_issue_ignored", 64'(mult_cnt), 64'd1);
        run_op(0, 5'd3, 1, 32'h6, 0, 0, 0, 0);
        chk("b2b_wb", last_wb, {27'd0, 5'd3, 32'h6});
        chk("still_sticky", 64'(timeout_err), 64'd1);

        run_op(0, 5'd6, 3, 32'h1, 0, 2, 0, 0);
        chk("reset_no_wb", last_wb, 64'd0);
        chk("reset_clears_flag", 64'(timeout_err), 64'd0);

        run_op(1, 5'd11, 4, 32'hCAFE, 0, 0, 0, 0);
        chk("post_reset_wb", last_wb, {27'd0, 5'd11, 32'hCAFE});
        chk("post_reset_stall", 64'(stall_cnt), 64'd5);

        chk_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
